// File: rtl/ram_arb_pkg.sv
// Shared types and width defaults for the two-port memory arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 64;
    localparam int RAM_BE_W   = RAM_DATA_W / 8;

    // Identifies which requester a command or read return belongs to.
    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // One read-pipeline stage: a read is in flight for the tagged port.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

    // Command fields as presented to the memory slave.
    typedef struct packed {
        logic                  write;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
        logic [RAM_BE_W-1:0]   be;
    } ram_cmd_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Tracks in-flight reads and steers memory read data back to the issuing port.
// Latency: readdata sampled READ_LATENCY cycles after issue, rvalid/rdata one cycle later.
// Backpressure: none; read returns cannot be stalled.
module ram_arb_rd_pipe
    import ram_arb_pkg::*;
#(
    parameter int DATA_W       = RAM_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_vld,
    input  logic              issue_port,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              pipe_busy
);

    rd_tag_t [READ_LATENCY-1:0] tag_q, tag_d;
    rd_tag_t                    tag_out;
    logic                       p0_rvalid_q, p0_rvalid_d;
    logic                       p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0]          p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]          p1_rdata_q, p1_rdata_d;

    // Shift the tag of the read issued this cycle; the last stage lines up with valid readdata.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = '{valid: issue_vld, port: issue_port};
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        tag_out     = tag_q[READ_LATENCY-1];
        p0_rvalid_d = tag_out.valid && (tag_out.port == PORT0);
        p1_rvalid_d = tag_out.valid && (tag_out.port == PORT1);
        p0_rdata_d  = p0_rvalid_d ? ram_readdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? ram_readdata : p1_rdata_q;
        pipe_busy   = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_busy = pipe_busy | tag_q[i].valid;
        end
    end

    // Reset drops every in-flight read so no stale rvalid can follow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q       <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            tag_q       <= tag_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin share of one memory slave port between the sequencer (p0) and mailbox writer (p1); RAM_ARB_STATS_EN adds grant counters.
// Latency: command and ack appear the cycle after the request edge; read data READ_LATENCY+1 cycles after issue.
// Backpressure: requests are held until ack; a port whose ack is high is skipped, so one port issues at most every other cycle.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int DATA_W       = RAM_DATA_W,
    parameter int READ_LATENCY = 1,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [BE_W-1:0]   p0_be,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [BE_W-1:0]   p1_be,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [BE_W-1:0]   ram_byteenable,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              busy
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [31:0]       p0_grant_cnt,
    output logic [31:0]       p1_grant_cnt
`endif
);

    logic              p0_elig, p1_elig, grant_vld;
    port_id_t          grant_port;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_writedata_q, ram_writedata_d;
    logic [BE_W-1:0]   ram_byteenable_q, ram_byteenable_d;
    logic              ram_chipselect_q, ram_chipselect_d;
    logic              ram_write_q, ram_write_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    port_id_t          last_grant_q, last_grant_d;
    port_id_t          issue_port_q, issue_port_d;
    logic              pipe_busy;

    // Pick a port (ties go to the one not granted last) and stage its command for issue.
    always_comb begin
        p0_elig    = p0_req && !p0_ack_q;
        p1_elig    = p1_req && !p1_ack_q;
        grant_vld  = p0_elig || p1_elig;
        if (p0_elig && p1_elig) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = p1_elig ? PORT1 : PORT0;
        end
        ram_address_d    = ram_address_q;
        ram_writedata_d  = ram_writedata_q;
        ram_byteenable_d = ram_byteenable_q;
        ram_chipselect_d = 1'b0;
        ram_write_d      = 1'b0;
        p0_ack_d         = 1'b0;
        p1_ack_d         = 1'b0;
        last_grant_d     = last_grant_q;
        issue_port_d     = issue_port_q;
        if (grant_vld) begin
            ram_chipselect_d = 1'b1;
            last_grant_d     = grant_port;
            issue_port_d     = grant_port;
            if (grant_port == PORT1) begin
                ram_address_d    = p1_addr;
                ram_writedata_d  = p1_wdata;
                ram_byteenable_d = p1_be;
                ram_write_d      = p1_write;
                p1_ack_d         = 1'b1;
            end else begin
                ram_address_d    = p0_addr;
                ram_writedata_d  = p0_wdata;
                ram_byteenable_d = p0_be;
                ram_write_d      = p0_write;
                p0_ack_d         = 1'b1;
            end
        end
    end

    // Command and ack registers; last_grant resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_address_q    <= '0;
            ram_writedata_q  <= '0;
            ram_byteenable_q <= '1;
            ram_chipselect_q <= 1'b0;
            ram_write_q      <= 1'b0;
            p0_ack_q         <= 1'b0;
            p1_ack_q         <= 1'b0;
            last_grant_q     <= PORT1;
            issue_port_q     <= PORT0;
        end else begin
            ram_address_q    <= ram_address_d;
            ram_writedata_q  <= ram_writedata_d;
            ram_byteenable_q <= ram_byteenable_d;
            ram_chipselect_q <= ram_chipselect_d;
            ram_write_q      <= ram_write_d;
            p0_ack_q         <= p0_ack_d;
            p1_ack_q         <= p1_ack_d;
            last_grant_q     <= last_grant_d;
            issue_port_q     <= issue_port_d;
        end
    end

    ram_arb_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_vld    (ram_chipselect_q && !ram_write_q),
        .issue_port   (issue_port_q),
        .ram_readdata (ram_readdata),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .pipe_busy    (pipe_busy)
    );

    assign ram_address    = ram_address_q;
    assign ram_writedata  = ram_writedata_q;
    assign ram_byteenable = ram_byteenable_q;
    assign ram_chipselect = ram_chipselect_q;
    assign ram_write      = ram_write_q;
    assign ram_clken      = 1'b1;
    assign p0_ack         = p0_ack_q;
    assign p1_ack         = p1_ack_q;
    assign busy           = ram_chipselect_q || pipe_busy;

`ifdef RAM_ARB_STATS_EN
    logic [31:0] p0_grant_cnt_q, p0_grant_cnt_d;
    logic [31:0] p1_grant_cnt_q, p1_grant_cnt_d;

    // Saturating per-port grant counts; a clear in the same cycle as an ack wins.
    always_comb begin
        p0_grant_cnt_d = p0_grant_cnt_q;
        p1_grant_cnt_d = p1_grant_cnt_q;
        if (stats_clr) begin
            p0_grant_cnt_d = '0;
            p1_grant_cnt_d = '0;
        end else begin
            if (p0_ack_q && (p0_grant_cnt_q != '1)) p0_grant_cnt_d = p0_grant_cnt_q + 32'd1;
            if (p1_ack_q && (p1_grant_cnt_q != '1)) p1_grant_cnt_d = p1_grant_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p0_grant_cnt_q <= '0;
            p1_grant_cnt_q <= '0;
        end else begin
            p0_grant_cnt_q <= p0_grant_cnt_d;
            p1_grant_cnt_q <= p1_grant_cnt_d;
        end
    end

    assign p0_grant_cnt = p0_grant_cnt_q;
    assign p1_grant_cnt = p1_grant_cnt_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (read latency 1 and 3) share one stimulus stream.
// A transaction-level model predicts grants, memory contents and read returns per cycle.
// Directed scenarios first, then randomized traffic with a reset in the middle.
module tb_ram_port_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #4 clk = ~clk;

    logic        i_req   [2];
    logic        i_wr    [2];
    logic [8:0]  i_addr  [2];
    logic [63:0] i_wdata [2];
    logic [7:0]  i_be    [2];

    logic        o_ack0 [2];
    logic        o_ack1 [2];
    logic        o_rv0  [2];
    logic        o_rv1  [2];
    logic [63:0] o_rd0  [2];
    logic [63:0] o_rd1  [2];
    logic [8:0]  o_addr [2];
    logic        o_cs   [2];
    logic        o_ck   [2];
    logic        o_wr   [2];
    logic [63:0] o_wd   [2];
    logic [7:0]  o_be   [2];
    logic [63:0] o_rdd  [2];
    logic        o_busy [2];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [63:0] init_val(input logic [8:0] a);
        if (a == 9'h005) return 64'hDEAD_BEEF_0000_0001;
        return {16'hA5A5, 7'h0, a, 16'h5A5A, 7'h0, ~a};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int LAT = (d == 0) ? LAT0 : LAT1;

        ram_port_arbiter #(.READ_LATENCY(LAT)) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .p0_req         (i_req[0]),
            .p0_write       (i_wr[0]),
            .p0_addr        (i_addr[0]),
            .p0_wdata       (i_wdata[0]),
            .p0_be          (i_be[0]),
            .p0_ack         (o_ack0[d]),
            .p0_rvalid      (o_rv0[d]),
            .p0_rdata       (o_rd0[d]),
            .p1_req         (i_req[1]),
            .p1_write       (i_wr[1]),
            .p1_addr        (i_addr[1]),
            .p1_wdata       (i_wdata[1]),
            .p1_be          (i_be[1]),
            .p1_ack         (o_ack1[d]),
            .p1_rvalid      (o_rv1[d]),
            .p1_rdata       (o_rd1[d]),
            .ram_address    (o_addr[d]),
            .ram_chipselect (o_cs[d]),
            .ram_clken      (o_ck[d]),
            .ram_write      (o_wr[d]),
            .ram_writedata  (o_wd[d]),
            .ram_byteenable (o_be[d]),
            .ram_readdata   (o_rdd[d]),
            .busy           (o_busy[d])
        );

        // Memory slave with LAT cycles of read latency.
        logic [63:0] mem   [512];
        bit          wrt   [512];
        logic [63:0] rpipe [LAT];

        always @(posedge clk) begin : p_mem
            logic [63:0] v;
            v = wrt[o_addr[d]] ? mem[o_addr[d]] : init_val(o_addr[d]);
            if (o_cs[d] && o_wr[d]) begin
                for (int b = 0; b < 8; b++) begin
                    if (o_be[d][b]) v[8*b +: 8] = o_wd[d][8*b +: 8];
                end
                mem[o_addr[d]] = v;
                wrt[o_addr[d]] = 1'b1;
            end
            rpipe[0] <= v;
            for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        end
        assign o_rdd[d] = rpipe[LAT-1];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          issue;
        bit          port;
        logic [63:0] data;
    } rd_t;

    rd_t         rq [$];
    logic [63:0] ref_mem [512];
    bit          ref_wrt [512];
    int          cyc;
    bit          m_ack [2];
    bit          m_last, m_cs, m_wr, m_port;
    logic [8:0]  m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [63:0] m_rdata [2][2];

    function automatic logic [63:0] ref_read(input logic [8:0] a);
        return ref_wrt[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic ref_write(input logic [8:0] a, input logic [63:0] w, input logic [7:0] be);
        logic [63:0] v;
        v = ref_read(a);
        for (int b = 0; b < 8; b++) begin
            if (be[b]) v[8*b +: 8] = w[8*b +: 8];
        end
        ref_mem[a] = v;
        ref_wrt[a] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ack[0] = 1'b0;
        m_ack[1] = 1'b0;
        m_last   = 1'b1;
        m_cs     = 1'b0;
        m_wr     = 1'b0;
        m_port   = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = 8'hFF;
        for (int d = 0; d < 2; d++) begin
            m_rdata[d][0] = '0;
            m_rdata[d][1] = '0;
        end
        rq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_cs", tag, d), o_cs[d], 0);
            chk($sformatf("%s_d%0d_wr", tag, d), o_wr[d], 0);
            chk($sformatf("%s_d%0d_addr", tag, d), o_addr[d], 0);
            chk($sformatf("%s_d%0d_wdata", tag, d), o_wd[d], 0);
            chk($sformatf("%s_d%0d_be", tag, d), o_be[d], 64'hFF);
            chk($sformatf("%s_d%0d_clken", tag, d), o_ck[d], 1);
            chk($sformatf("%s_d%0d_ack0", tag, d), o_ack0[d], 0);
            chk($sformatf("%s_d%0d_ack1", tag, d), o_ack1[d], 0);
            chk($sformatf("%s_d%0d_rv0", tag, d), o_rv0[d], 0);
            chk($sformatf("%s_d%0d_rv1", tag, d), o_rv1[d], 0);
            chk($sformatf("%s_d%0d_rd0", tag, d), o_rd0[d], 0);
            chk($sformatf("%s_d%0d_rd1", tag, d), o_rd1[d], 0);
            chk($sformatf("%s_d%0d_busy", tag, d), o_busy[d], 0);
        end
    endtask

    task automatic check_cycle();
        bit e_rv [2];
        bit e_busy;
        int l;
        for (int d = 0; d < 2; d++) begin
            l = lat_of(d);
            e_rv[0] = 1'b0;
            e_rv[1] = 1'b0;
            e_busy  = m_cs;
            foreach (rq[i]) begin
                if (rq[i].issue + l + 1 == cyc) begin
                    e_rv[rq[i].port] = 1'b1;
                    m_rdata[d][rq[i].port] = rq[i].data;
                end
                if (rq[i].issue < cyc && cyc <= rq[i].issue + l) e_busy = 1'b1;
            end
            chk($sformatf("c%0d_d%0d_ack0", cyc, d), o_ack0[d], m_ack[0]);
            chk($sformatf("c%0d_d%0d_ack1", cyc, d), o_ack1[d], m_ack[1]);
            chk($sformatf("c%0d_d%0d_cs", cyc, d), o_cs[d], m_cs);
            chk($sformatf("c%0d_d%0d_wr", cyc, d), o_wr[d], m_wr);
            chk($sformatf("c%0d_d%0d_addr", cyc, d), o_addr[d], m_addr);
            chk($sformatf("c%0d_d%0d_wdata", cyc, d), o_wd[d], m_wdata);
            chk($sformatf("c%0d_d%0d_be", cyc, d), o_be[d], m_be);
            chk($sformatf("c%0d_d%0d_clken", cyc, d), o_ck[d], 1);
            chk($sformatf("c%0d_d%0d_busy", cyc, d), o_busy[d], e_busy);
            chk($sformatf("c%0d_d%0d_rv0", cyc, d), o_rv0[d], e_rv[0]);
            chk($sformatf("c%0d_d%0d_rv1", cyc, d), o_rv1[d], e_rv[1]);
            chk($sformatf("c%0d_d%0d_rd0", cyc, d), o_rd0[d], m_rdata[d][0]);
            chk($sformatf("c%0d_d%0d_rd1", cyc, d), o_rd1[d], m_rdata[d][1]);
        end
        while (rq.size() > 0 && rq[0].issue + LAT1 + 1 <= cyc) void'(rq.pop_front());
    endtask

    // Advance one clock: predict the grant from the inputs held across the edge, then check.
    task automatic step();
        bit          e0, e1;
        int          g;
        bit          g_wr;
        logic [8:0]  g_addr;
        logic [63:0] g_wdata;
        logic [7:0]  g_be;
        rd_t         r;
        e0 = i_req[0] && !m_ack[0];
        e1 = i_req[1] && !m_ack[1];
        g  = -1;
        if (e0 && e1) g = m_last ? 0 : 1;
        else if (e0) g = 0;
        else if (e1) g = 1;
        if (g >= 0) begin
            g_wr    = i_wr[g];
            g_addr  = i_addr[g];
            g_wdata = i_wdata[g];
            g_be    = i_be[g];
        end
        if (m_cs) begin
            if (m_wr) begin
                ref_write(m_addr, m_wdata, m_be);
            end else begin
                r.issue = cyc;
                r.port  = m_port;
                r.data  = ref_read(m_addr);
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_ack[0] = (g == 0);
        m_ack[1] = (g == 1);
        if (g >= 0) begin
            m_cs    = 1'b1;
            m_port  = (g == 1);
            m_last  = (g == 1);
            m_wr    = g_wr;
            m_addr  = g_addr;
            m_wdata = g_wdata;
            m_be    = g_be;
        end else begin
            m_cs = 1'b0;
            m_wr = 1'b0;
        end
        check_cycle();
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic set_cmd(input int p, input bit req, input bit wr, input logic [8:0] a,
                           input logic [63:0] w, input logic [7:0] be);
        i_req[p]   = req;
        i_wr[p]    = wr;
        i_addr[p]  = a;
        i_wdata[p] = w;
        i_be[p]    = be;
    endtask

    task automatic rand_drive();
        for (int p = 0; p < 2; p++) begin
            if (!i_req[p] || m_ack[p]) begin
                i_req[p]   = ($urandom_range(0, 3) != 0);
                i_wr[p]    = ($urandom_range(0, 1) == 1);
                i_addr[p]  = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'(32 + $urandom_range(0, 7));
                i_wdata[p] = {$urandom, $urandom};
                i_be[p]    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
        end
    endtask

    initial begin
        int cnt;
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        set_cmd(1, 0, 0, '0, '0, 8'hFF);
        cyc = 0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset_n = 1'b1;
        model_reset();

        // Tie: both ports hold reads; grants alternate starting with port 0.
        set_cmd(0, 1, 0, 9'h010, '0, 8'hFF);
        set_cmd(1, 1, 0, 9'h011, '0, 8'hFF);
        step();
        chk("tie_first_p0", o_ack0[0], 1);
        repeat (7) step();
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        set_cmd(1, 0, 0, '0, '0, 8'hFF);
        repeat (5) step();

        // Single read of the preloaded word.
        set_cmd(0, 1, 0, 9'h005, '0, 8'hFF);
        step();
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        repeat (4) step();
        chk("single_rdata_l1", o_rd0[0], 64'hDEAD_BEEF_0000_0001);
        chk("single_rdata_l3", o_rd0[1], 64'hDEAD_BEEF_0000_0001);

        // Held write request on port 1 for four edges: two issues, never back to back.
        set_cmd(1, 1, 1, 9'h1FF, 64'h0123_4567_89AB_CDEF, 8'h0F);
        cnt = 0;
        repeat (4) begin
            step();
            cnt += int'(o_ack1[0]);
        end
        chk("held_ack_count", cnt, 2);
        set_cmd(1, 0, 0, '0, '0, 8'hFF);
        repeat (2) step();

        // Write then read of the same word on the other port in the next cycle.
        set_cmd(1, 1, 1, 9'h020, 64'h1234, 8'hFF);
        step();
        set_cmd(1, 0, 0, '0, '0, 8'hFF);
        set_cmd(0, 1, 0, 9'h020, '0, 8'hFF);
        step();
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        repeat (4) step();
        chk("raw_rdata_l1", o_rd0[0], 64'h1234);
        chk("raw_rdata_l3", o_rd0[1], 64'h1234);

        // Reset one cycle after a read ack: the read is dropped.
        set_cmd(0, 1, 0, 9'h007, '0, 8'hFF);
        step();
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        step();
        do_reset("midrd");
        cnt = 0;
        repeat (6) begin
            step();
            cnt += int'(o_rv0[0]) + int'(o_rv0[1]);
        end
        chk("midrd_no_rvalid", cnt, 0);

        // Random traffic with a reset part way through.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rnd");
            rand_drive();
            step();
        end
        set_cmd(0, 0, 0, '0, '0, 8'hFF);
        set_cmd(1, 0, 0, '0, '0, 8'hFF);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
